// File: rtl/push_pkg.sv
// Shared constants and helpers for the receive-side push FIFO.
package push_pkg;

   localparam int unsigned BYTE_WIDTH = 8;

   // Fill level spans 0..DEPTH inclusive, so it needs one bit beyond the pointers.
   function automatic int unsigned count_width(input int unsigned depth_log2);
      return depth_log2 + 1;
   endfunction

endpackage

// File: rtl/push_ram.sv
// Simple dual-port memory: registered write, asynchronous read (distributed RAM).
module push_ram #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/push_rx_fifo.sv
// Byte FIFO behind the RS232 receiver: push-in without backpressure, valid/ready out,
// RTS flow control derived from fill level, sticky overflow on dropped bytes.
module push_rx_fifo
   import push_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2    = 4,
   parameter int unsigned RTS_THRESHOLD = 12
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [BYTE_WIDTH-1:0]              idata,
   input  logic                               istrobe,
   output logic                               rtsn,
   output logic [BYTE_WIDTH-1:0]              odata,
   output logic                               ovalid,
   input  logic                               oready,
   output logic [count_width(DEPTH_LOG2)-1:0] count,
   output logic                               overflow
);

   localparam int unsigned CW    = count_width(DEPTH_LOG2);
   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] THRESH_C = CW'(RTS_THRESHOLD);

   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic [CW-1:0]         count_next;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  accept;
   logic                  drop;

   assign push = istrobe;
   assign pop  = ovalid & oready;
   assign full = (count == DEPTH_C);

   // A push into a full FIFO still lands if the head leaves on the same edge.
   assign accept = push & (~full | pop);
   assign drop   = push & full & ~pop;

   always_comb begin
      count_next = count;
      if (accept && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !accept) begin
         count_next = count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         ovalid   <= 1'b0;
         overflow <= 1'b0;
         rtsn     <= 1'b1;
      end else begin
         if (accept) begin
            wptr <= wptr + DEPTH_LOG2'(1);
         end
         if (pop) begin
            rptr <= rptr + DEPTH_LOG2'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         count  <= count_next;
         ovalid <= (count_next != '0);
         rtsn   <= (count_next >= THRESH_C);
      end
   end

   push_ram #(
      .ADDR_WIDTH (DEPTH_LOG2),
      .DATA_WIDTH (BYTE_WIDTH)
   ) u_ram (
      .clock (clock),
      .we    (accept),
      .waddr (wptr),
      .wdata (idata),
      .raddr (rptr),
      .rdata (odata)
   );

endmodule

// File: tb/tb_push_rx_fifo.sv
// Directed and constrained-random checks for push_rx_fifo at DEPTH_LOG2=4, RTS_THRESHOLD=12.
module tb_push_rx_fifo;

   logic       clock;
   logic       reset;
   logic [7:0] idata;
   logic       istrobe;
   logic       rtsn;
   logic [7:0] odata;
   logic       ovalid;
   logic       oready;
   logic [4:0] count;
   logic       overflow;

   int unsigned vectors;
   int unsigned miscompares;

   push_rx_fifo #(
      .DEPTH_LOG2    (4),
      .RTS_THRESHOLD (12)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .idata    (idata),
      .istrobe  (istrobe),
      .rtsn     (rtsn),
      .odata    (odata),
      .ovalid   (ovalid),
      .oready   (oready),
      .count    (count),
      .overflow (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      istrobe = 1'b0;
      oready  = 1'b0;
      idata   = 8'h00;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      istrobe = 1'b1;
      idata   = 8'hEE;
      oready  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (rtsn !== 1'b1 || ovalid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold cyc%0d: rtsn=%b ovalid=%b count=%0d ovf=%b, want 1 0 0 0",
                     i, rtsn, ovalid, count, overflow);
         end
      end
      istrobe = 1'b0;
      oready  = 1'b0;
      reset   = 1'b0;
      step();
      vectors++;
      if (rtsn !== 1'b0 || ovalid !== 1'b0 || count !== 5'd0) begin
         miscompares++;
         $display("FAIL reset_release: rtsn=%b ovalid=%b count=%0d, want 0 0 0", rtsn, ovalid, count);
      end
   endtask

   task automatic test_single();
      istrobe = 1'b1;
      idata   = 8'hA5;
      step();
      istrobe = 1'b0;
      idata   = 8'h00;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (ovalid !== 1'b1 || odata !== 8'hA5 || count !== 5'd1) begin
            miscompares++;
            $display("FAIL single_push t%0d: ovalid=%b odata=%h count=%0d, want 1 a5 1",
                     i, ovalid, odata, count);
         end
         if (i == 0) step();
      end
      oready = 1'b1;
      step();
      oready = 1'b0;
      vectors++;
      if (ovalid !== 1'b0 || count !== 5'd0) begin
         miscompares++;
         $display("FAIL single_pop: ovalid=%b count=%0d, want 0 0", ovalid, count);
      end
   endtask

   task automatic test_threshold();
      for (int i = 0; i < 12; i++) begin
         istrobe = 1'b1;
         idata   = 8'(i);
         step();
         vectors++;
         if (count !== 5'(i + 1) || rtsn !== (i + 1 >= 12)) begin
            miscompares++;
            $display("FAIL thresh_fill %0d: count=%0d rtsn=%b, want %0d %b",
                     i, count, rtsn, i + 1, (i + 1 >= 12));
         end
      end
      istrobe = 1'b0;
      oready  = 1'b1;
      step();
      oready = 1'b0;
      vectors++;
      if (count !== 5'd11 || rtsn !== 1'b0 || odata !== 8'h01) begin
         miscompares++;
         $display("FAIL thresh_pop: count=%0d rtsn=%b odata=%h, want 11 0 01", count, rtsn, odata);
      end
      for (int k = 1; k < 12; k++) begin
         vectors++;
         if (ovalid !== 1'b1 || odata !== 8'(k)) begin
            miscompares++;
            $display("FAIL thresh_drain %0d: ovalid=%b odata=%h, want 1 %h", k, ovalid, odata, 8'(k));
         end
         oready = 1'b1;
         step();
         oready = 1'b0;
      end
      vectors++;
      if (ovalid !== 1'b0 || count !== 5'd0) begin
         miscompares++;
         $display("FAIL thresh_empty: ovalid=%b count=%0d, want 0 0", ovalid, count);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         istrobe = 1'b1;
         idata   = 8'(8'h10 + i);
         step();
         if (i == 15) begin
            vectors++;
            if (count !== 5'd16 || overflow !== 1'b0 || rtsn !== 1'b1) begin
               miscompares++;
               $display("FAIL ovf_full: count=%0d ovf=%b rtsn=%b, want 16 0 1", count, overflow, rtsn);
            end
         end
      end
      istrobe = 1'b0;
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_drop: count=%0d ovf=%b, want 16 1", count, overflow);
      end
      for (int k = 0; k < 16; k++) begin
         vectors++;
         if (ovalid !== 1'b1 || odata !== 8'(8'h10 + k)) begin
            miscompares++;
            $display("FAIL ovf_drain %0d: ovalid=%b odata=%h, want 1 %h", k, ovalid, odata, 8'(8'h10 + k));
         end
         oready = 1'b1;
         step();
         oready = 1'b0;
      end
      vectors++;
      if (ovalid !== 1'b0 || count !== 5'd0 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_after: ovalid=%b count=%0d ovf=%b, want 0 0 1", ovalid, count, overflow);
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         istrobe = 1'b1;
         idata   = 8'(8'h40 + i);
         step();
      end
      istrobe = 1'b1;
      idata   = 8'h77;
      oready  = 1'b1;
      step();
      istrobe = 1'b0;
      oready  = 1'b0;
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b0 || odata !== 8'h41) begin
         miscompares++;
         $display("FAIL fullpp: count=%0d ovf=%b odata=%h, want 16 0 41", count, overflow, odata);
      end
      for (int k = 0; k < 16; k++) begin
         logic [7:0] want;
         want = (k == 15) ? 8'h77 : 8'(8'h41 + k);
         vectors++;
         if (ovalid !== 1'b1 || odata !== want) begin
            miscompares++;
            $display("FAIL fullpp_drain %0d: ovalid=%b odata=%h, want 1 %h", k, ovalid, odata, want);
         end
         oready = 1'b1;
         step();
         oready = 1'b0;
      end
      vectors++;
      if (ovalid !== 1'b0 || count !== 5'd0) begin
         miscompares++;
         $display("FAIL fullpp_empty: ovalid=%b count=%0d, want 0 0", ovalid, count);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  q[$];
      int unsigned pushes;
      int unsigned pops;
      int unsigned cycles;
      logic        do_push;
      logic        do_pop;
      do_reset();
      pushes = 0;
      pops   = 0;
      cycles = 0;
      while ((pushes < 1000 || q.size() != 0) && cycles < 20000) begin
         do_push = (pushes < 1000) && (q.size() < 15) && ($urandom_range(0, 9) < 6);
         istrobe = do_push;
         idata   = 8'($urandom);
         oready  = (pushes >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
         vectors++;
         if (ovalid !== (q.size() != 0) || (q.size() != 0 && odata !== q[0])) begin
            miscompares++;
            $display("FAIL stress_out cyc%0d: ovalid=%b odata=%h, want %b %h",
                     cycles, ovalid, odata, (q.size() != 0), (q.size() != 0) ? q[0] : 8'h00);
         end
         do_pop = oready && (q.size() != 0);
         if (do_push) q.push_back(idata);
         step();
         if (do_pop) begin
            void'(q.pop_front());
            pops++;
         end
         if (do_push) pushes++;
         cycles++;
         vectors++;
         if (count !== 5'(q.size()) || rtsn !== (q.size() >= 12)) begin
            miscompares++;
            $display("FAIL stress_cnt cyc%0d: count=%0d rtsn=%b, want %0d %b",
                     cycles, count, rtsn, q.size(), (q.size() >= 12));
         end
      end
      istrobe = 1'b0;
      oready  = 1'b0;
      vectors++;
      if (cycles >= 20000) begin
         miscompares++;
         $display("FAIL stress_timeout: cycles=%0d pushes=%0d, want completion", cycles, pushes);
      end
      vectors++;
      if (pops / 16 <= 60 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL stress_wrap: wraps=%0d ovf=%b, want >60 0", pops / 16, overflow);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      istrobe     = 1'b0;
      oready      = 1'b0;
      idata       = 8'h00;
      test_reset();
      test_single();
      test_threshold();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
